// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and carry-lookahead helpers for the pipelined CLA adder.
package pipelined_cla_adder_pkg;

  // Width of one lookahead slice; one slice is resolved per pipeline stage.
  localparam int SLICE_W = 16;

  // Number of pipeline stages for a given operand width.
  function automatic int nstage_of(input int width);
    return width / SLICE_W;
  endfunction

  // Lookahead carries into bits 0..3 of a 4-bit group (bit 0 gets ci).
  function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group generate of a 4-bit group (carry out assuming no carry in).
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder_slice.sv
// Combinational 16-bit carry-lookahead slice: four 4-bit groups plus a
// group carry unit. c15 is the carry into bit 15, used for signed overflow.
module cla16_slice
  import pipelined_cla_adder_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co,
  output logic        c15
);

  logic [15:0] p_s;
  logic [15:0] g_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [3:0]  gc_s;

  // Bit and group generate/propagate, group carries, then bit carries and sum.
  always_comb begin
    p_s = a ^ b;
    g_s = a & b;
    for (int j = 0; j < 4; j++) begin
      gg_s[j] = grp_gen(g_s[4*j +: 4], p_s[4*j +: 4]);
      gp_s[j] = &p_s[4*j +: 4];
    end
    // The group carry unit has the same lookahead form as a 4-bit group.
    gc_s = cla4_carries(gg_s, gp_s, ci);
    for (int j = 0; j < 4; j++) begin
      c_s[4*j +: 4] = cla4_carries(g_s[4*j +: 4], p_s[4*j +: 4], gc_s[j]);
    end
    s   = p_s ^ c_s;
    co  = grp_gen(gg_s, gp_s) | ((&gp_s) & ci);
    c15 = c_s[15];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. One 16-bit slice is resolved
// per stage and the inter-slice carry is registered, so the critical path is
// one slice regardless of WIDTH. A global stall gives full backpressure.
module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_adder_if.slave  bus
);
  import pipelined_cla_adder_pkg::*;

  localparam int NSTAGE = nstage_of(WIDTH);
  localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({SLICE_W{1'b1}});

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of 16");
  end

  logic             adv_s;
  logic             c0_s;
  logic [WIDTH-1:0] bx_s;

  // Stage registers
  logic             vld_r [NSTAGE];
  logic             cy_r  [NSTAGE];
  logic [WIDTH-1:0] sum_r [NSTAGE];
  logic [WIDTH-1:0] opa_r [NSTAGE];
  logic [WIDTH-1:0] opb_r [NSTAGE];
  logic             ovf_r;

  // What each stage sees from its predecessor (or from the input port)
  logic             vld_in_s [NSTAGE];
  logic             ci_in_s  [NSTAGE];
  logic [WIDTH-1:0] sum_in_s [NSTAGE];
  logic [WIDTH-1:0] opa_in_s [NSTAGE];
  logic [WIDTH-1:0] opb_in_s [NSTAGE];
  logic [WIDTH-1:0] sum_nxt_s[NSTAGE];
  logic [15:0]      sl_s_s   [NSTAGE];
  logic             sl_co_s  [NSTAGE];
  logic             sl_c15_s [NSTAGE];

  // Whole pipeline moves when the output slot is empty or being consumed.
  assign adv_s = bus.out_ready | ~vld_r[NSTAGE-1];
  // Subtraction is A + ~B + 1; cin only matters for addition.
  assign bx_s  = bus.sub ? ~bus.b : bus.b;
  assign c0_s  = bus.sub | bus.cin;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_entry
      assign vld_in_s[k] = bus.in_valid & adv_s;
      assign ci_in_s[k]  = c0_s;
      assign sum_in_s[k] = '0;
      assign opa_in_s[k] = bus.a;
      assign opb_in_s[k] = bx_s;
    end else begin : g_link
      assign vld_in_s[k] = vld_r[k-1];
      assign ci_in_s[k]  = cy_r[k-1];
      assign sum_in_s[k] = sum_r[k-1];
      assign opa_in_s[k] = opa_r[k-1];
      assign opb_in_s[k] = opb_r[k-1];
    end

    cla16_slice u_slice (
      .a   (opa_in_s[k][k*SLICE_W +: SLICE_W]),
      .b   (opb_in_s[k][k*SLICE_W +: SLICE_W]),
      .ci  (ci_in_s[k]),
      .s   (sl_s_s[k]),
      .co  (sl_co_s[k]),
      .c15 (sl_c15_s[k])
    );

    // Splice this stage's freshly resolved slice into the partial sum.
    assign sum_nxt_s[k] = (sum_in_s[k] & ~(SL_MASK << (k*SLICE_W)))
                        | (WIDTH'(sl_s_s[k]) << (k*SLICE_W));
  end

  // Stage registers: shift forward on advance, hold on stall, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        vld_r[k] <= 1'b0;
        cy_r[k]  <= 1'b0;
        sum_r[k] <= '0;
        opa_r[k] <= '0;
        opb_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < NSTAGE; k++) begin
        vld_r[k] <= vld_in_s[k];
        cy_r[k]  <= sl_co_s[k];
        sum_r[k] <= sum_nxt_s[k];
        opa_r[k] <= opa_in_s[k];
        opb_r[k] <= opb_in_s[k];
      end
      ovf_r <= sl_c15_s[NSTAGE-1] ^ sl_co_s[NSTAGE-1];
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = vld_r[NSTAGE-1];
  assign bus.sum       = sum_r[NSTAGE-1];
  assign bus.cout      = cy_r[NSTAGE-1];
  assign bus.ovf       = ovf_r;
  assign bus.zero      = ~|sum_r[NSTAGE-1];

endmodule
